rda_div: RTL and testbench
==========================

RDA_DIV -- requirements
Module: rda_div

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, setting the operand, quotient and remainder width (legal range 2..64).
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk: input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port start: input, 1 bit, request to begin a division using the current x and y.
REQ-006 Port x: input, WIDTH bits, unsigned dividend.
REQ-007 Port y: input, WIDTH bits, unsigned divisor.
REQ-008 Port busy: output, 1 bit, high while a division is in progress.
REQ-009 Port done: output, 1 bit, one-cycle pulse marking valid q and r.
REQ-010 Port q: output, WIDTH bits, unsigned quotient.
REQ-011 Port r: output, WIDTH bits, unsigned remainder.
REQ-012 Port div_by_zero: output, 1 bit, high with the result when the latched y was 0.

Function
REQ-013 The divider SHALL implement the restoring division algorithm, producing one quotient bit per clock cycle, MSB first.
REQ-014 The divider SHALL have a state machine with states IDLE, RUN and DONE.
- IDLE: start=1 moves to RUN; start=0 stays in IDLE.
- RUN: moves to DONE after WIDTH iterations.
- DONE: lasts exactly one cycle, then returns to IDLE.
REQ-015 On the rising edge where start=1 in IDLE, the divider SHALL latch x and y, clear the partial remainder and iteration counter, and enter RUN.
REQ-016 Each RUN cycle SHALL perform one iteration:
- shift the (WIDTH+1)-bit partial remainder left by one, bringing in the next dividend bit;
- trial-subtract the zero-extended divisor;
- if the result is non-negative, keep it and set the quotient bit to 1;
- otherwise restore the previous value and set the quotient bit to 0.
REQ-017 After exactly WIDTH RUN cycles, the divider SHALL register the results and enter DONE, such that x == q*y + r and r < y for all y != 0.
REQ-018 Latency: done SHALL be high in the cycle following the (WIDTH+1)-th rising edge counted from, and including, the start-accept edge, i.e. WIDTH+1 cycles after acceptance.
REQ-019 busy SHALL be high from the cycle after start is accepted through the last RUN cycle, and low in IDLE and DONE.
REQ-020 done SHALL be high only in the DONE state, for exactly one cycle per accepted start.
REQ-021 q, r and div_by_zero SHALL hold their values from the DONE state until the next DONE state, or until reset.
REQ-022 start SHALL be ignored while in RUN or DONE, and x and y SHALL be ignored except on the accept edge.
REQ-023 A start asserted in the same cycle that done is high SHALL be ignored; start asserted in the following IDLE cycle SHALL be accepted.
REQ-024 When the latched y is 0, the divider SHALL use the same latency and produce q = all ones, r = x and div_by_zero = 1; otherwise div_by_zero SHALL be 0.
REQ-025 All arithmetic SHALL be unsigned with no overflow for any x and y in the range 0..2^WIDTH-1.

Reset
REQ-026 When rst_n=0, the divider SHALL immediately, without waiting for a clock edge, set state=IDLE, busy=0, done=0, q=0, r=0, div_by_zero=0, and clear the internal counter, partial remainder and operand registers.
REQ-027 Asserting reset during RUN SHALL abort the division with no done pulse, and after release the divider SHALL accept a new start normally.
REQ-028 After rst_n rises, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-029 Basic division, WIDTH=32: x=1436, y=135, start pulse -> done after 33 cycles with q=10, r=86, div_by_zero=0; busy high for 32 cycles.
REQ-030 Dividend smaller than divisor: x=5, y=7 -> q=0, r=5. Full-scale operands: x=32'hFFFFFFFF, y=1 -> q=32'hFFFFFFFF, r=0.
REQ-031 Divide by zero: x=100, y=0 -> q=32'hFFFFFFFF, r=100, div_by_zero=1, same 33-cycle latency.
REQ-032 Start while busy: start x=1436, y=135; in cycle 5 pulse start with x=9, y=3 -> exactly one done pulse, q=10, r=86; then a new start with x=9, y=3 -> q=3, r=0.
REQ-033 Reset mid-operation: start x=1436, y=135; drive rst_n low at cycle 10 between clock edges -> busy=0, q=0, r=0 immediately, and no done pulse; after release, start x=1000, y=33 -> q=30, r=10.
REQ-034 Randomized check: 1000 random x and y values, including y=0 -> every result satisfies REQ-017 or REQ-024.

Source files
------------

// File: rtl/rda_div.sv
// rtl/rda_div.sv - restoring unsigned divider, one quotient bit per cycle
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rst_n        - asynchronous active-low reset
//   start        - begin a division with the current x and y (accepted in IDLE only)
//   x, y         - unsigned dividend and divisor, sampled on the accept edge
//   busy         - high during the WIDTH iteration cycles
//   done         - one-cycle pulse when q, r and div_by_zero are updated
//   q, r         - quotient and remainder, held until the next result
//   div_by_zero  - set with the result when the latched divisor was zero

module rda_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;      // partial remainder, one guard bit for the trial subtract
    logic [WIDTH-1:0] xs_q, xs_d;        // dividend, shifted left so its MSB is the next bit in
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] quo_q, quo_d;      // quotient under construction
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH:0]   rem_next;

    // The partial remainder is always below 2^WIDTH, so after the shift it fits in
    // WIDTH+1 bits and the top bit of the difference is a reliable sign.
    always_comb begin
        shifted  = {rem_q[WIDTH-1:0], xs_q[WIDTH-1]};
        diff     = shifted - {1'b0, y_q};
        qbit     = ~diff[WIDTH];
        rem_next = qbit ? diff : shifted;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        xs_d    = xs_q;
        y_d     = y_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xs_d    = x;
                    y_d     = y;
                    rem_d   = '0;
                    cnt_d   = '0;
                    quo_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                xs_d  = xs_q << 1;
                rem_d = rem_next;
                quo_d = {quo_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // A zero divisor needs no special path: every trial subtract
                    // succeeds, giving all-ones quotient and r = x.
                    q_d     = {quo_q[WIDTH-2:0], qbit};
                    r_d     = rem_next[WIDTH-1:0];
                    dbz_d   = (y_q == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            xs_q    <= '0;
            y_q     <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            xs_q    <= xs_d;
            y_q     <= y_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_rda_div.sv
// tb/tb_rda_div.sv - randomized self-checking bench for rda_div

module tb_rda_div;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int done_cnt = 0;

    rda_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .x           (x),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // done is sampled just before each edge updates it, so each pulse cycle counts once
    always @(posedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            pass_cnt++;
    endtask

    // Wait, bounded, for the next negedge at which done is high; returns negedges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One full division. Optionally pulses start with other operands at cycle 'poke'.
    task automatic do_div(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input int poke, input logic [W-1:0] px, input logic [W-1:0] py);
        int n;
        int busy_n;
        int d0;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        eq = (yv == 0) ? {W{1'b1}} : xv / yv;
        er = (yv == 0) ? xv : xv % yv;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; x = xv; y = yv;
        @(negedge clk);
        // operands are scrambled after acceptance; the result must not depend on them
        start = 1'b0; x = $urandom; y = $urandom;
        n = 1; busy_n = 0;
        while (!done && n < 200) begin
            if (busy) busy_n++;
            if (n == poke) begin
                start = 1'b1; x = px; y = py;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(W + 1));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
        check({tag, "_q"}, 64'(q), 64'(eq));
        check({tag, "_r"}, 64'(r), 64'(er));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(yv == 0));
        @(negedge clk);
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_idle_after"}, 64'({busy, done}), 64'd0);
        check({tag, "_q_held"}, 64'(q), 64'(eq));
    endtask

    initial begin
        int n;
        int d0;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_q", 64'(q), 64'd0);
        check("rst_r", 64'(r), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;

        do_div("basic", 32'd1436, 32'd135, 0, '0, '0);
        do_div("small", 32'd5, 32'd7, 0, '0, '0);
        do_div("full", 32'hFFFF_FFFF, 32'd1, 0, '0, '0);
        do_div("dbz", 32'd100, 32'd0, 0, '0, '0);
        do_div("busy_start", 32'd1436, 32'd135, 5, 32'd9, 32'd3);
        do_div("after_busy", 32'd9, 32'd3, 0, '0, '0);

        // start held through the done cycle: ignored there, accepted in the next IDLE
        @(negedge clk);
        start = 1'b1; x = 32'd50; y = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("sd_first_q", 64'(q), 64'd7);
        start = 1'b1; x = 32'd20; y = 32'd6;
        @(negedge clk);
        check("sd_ignored_in_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("sd_accepted_idle", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(n);
        check("sd_q", 64'(q), 64'd3);
        check("sd_r", 64'(r), 64'd2);
        @(negedge clk);

        // reset in the middle of a division, asserted between edges
        @(negedge clk);
        start = 1'b1; x = 32'd1436; y = 32'd135;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_q", 64'(q), 64'd0);
        check("mid_rst_r", 64'(r), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        do_div("post_rst", 32'd1000, 32'd33, 0, '0, '0);

        for (int i = 0; i < 1000; i++) begin
            rx = $urandom;
            case ($urandom_range(0, 7))
                0:       ry = '0;
                1:       ry = 32'($urandom_range(1, 15));
                2:       ry = rx;
                3:       ry = $urandom >> $urandom_range(0, 31);
                default: ry = $urandom;
            endcase
            do_div("rand", rx, ry, 0, '0, '0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
